pipe_memory: RTL and testbench
==============================

Name: pipe_memory

Overview:
- Next-generation behavioural/synthesizable word memory for the CPU's instruction and data ports.
- Generalises the single-outstanding read-only memory to:
  - pipelined, in-order accesses with configurable latency;
  - multiple outstanding requests;
  - byte-strobed writes;
  - error responses.
- Sits between the core's fetch/LSU request logic and the backing store, using the existing valid/ready request and response handshakes.

Parameters:
- ADDRESS_WIDTH, 32, byte-address width.
- DATA_WIDTH, 32, word width; multiple of 8 and a power of two.
- DEPTH_WORDS, 1024, number of words stored; power of two.
- LATENCY, 2, cycles from request acceptance to response-FIFO entry; ≥1.
- RESP_DEPTH, 4, maximum outstanding requests (pipeline plus response FIFO); ≥LATENCY.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- i_address  in  ADDRESS_WIDTH  byte address of the request.
- i_cmd  in  1  MEM_CMD_READ=0, MEM_CMD_WRITE=1.
- i_data  in  DATA_WIDTH  write data.
- i_strb  in  DATA_WIDTH/8  byte write enables; bit n covers data[8n+7:8n].
- i_valid  in  1  request valid.
- o_ready  out  1  request can be accepted.
- o_data  out  DATA_WIDTH  read data; zero for write and error responses.
- o_err  out  1  response is an error.
- o_res_valid  out  1  response valid.
- i_res_ready  in  1  consumer accepts the response.

Behaviour:
- **Clock and reset.** One clock (clk); reset is synchronous and active-high.
- **Reset values.** o_ready=0, o_res_valid=0, o_data=0, o_err=0. The pipeline and response FIFO are emptied and the credit count is cleared. Memory contents are not cleared.
- **Reset mid-operation.** Reset mid-operation discards all in-flight requests without responses. Writes already accepted remain committed.
- **After reset.** o_ready rises on the first cycle after reset deasserts.
- **Request accept.** A request is accepted when i_valid && o_ready on a rising edge.
- **Credit rule.** o_ready = (outstanding < RESP_DEPTH).
  - outstanding increments on accept and decrements on response handshake.
  - A simultaneous accept and handshake leaves outstanding unchanged.
  - o_ready stays high at outstanding = RESP_DEPTH-1 when a handshake occurs that cycle.
  - o_ready is registered from the next-state count.
- **Address decode.**
  - word index = i_address >> log2(DATA_WIDTH/8).
  - Misaligned: low log2(DATA_WIDTH/8) address bits are nonzero.
  - Out of range: word index ≥ DEPTH_WORDS.
  - Misaligned or out-of-range requests produce o_err=1 and o_data=0. Errored writes do not modify memory.
- **Write.** The write commits in the acceptance cycle, updating only the bytes with i_strb set. The write produces one response with o_err=0 and o_data=0.
- **Read.** Data is sampled in the acceptance cycle. A write accepted in an earlier cycle is visible; a read never bypasses a later write.
- **Response timing.**
  - Every accepted request yields exactly one response, in acceptance order.
  - With no backpressure, o_res_valid asserts exactly LATENCY cycles after the accept edge.
  - Back-to-back accepts give back-to-back responses.
- **Backpressure.** While o_res_valid && !i_res_ready, o_data, o_err and o_res_valid hold stable. The pipeline keeps draining into the FIFO; credits guarantee no overflow.
- **Response FIFO.** Circular buffer of RESP_DEPTH entries. Pointers wrap modulo RESP_DEPTH. Simultaneous push and pop of a full FIFO is legal.
- **Per-stage state.** Each pipeline stage carries valid, err and data. There are no further FSM states beyond the credit counter and FIFO occupancy.

Optional Feature:
- **Macro: PIPE_MEM_BYTE_STROBE_EN.**
- **Defined:** partial writes per i_strb as above. i_strb==0 on a write is a legal no-op that still returns a response.
- **Undefined:** i_strb is ignored and every write updates the full word. Port i_strb remains present for interface stability.

Decomposition:
- **Shared package (mem_defs include):**
  - MEM_CMD_READ and MEM_CMD_WRITE constants;
  - a MEM_CMD_WIDTH of 1;
  - the response record layout {err, data};
  - a clog2 helper function.
- **Sub-module: mem_resp_fifo.**
  - Parameters: WIDTH, DEPTH.
  - Ports: clk, reset, push, push_data, pop, out_data, out_valid.
  - Instantiated once.
  - The latency shift pipeline and storage array stay in pipe_memory.

Test Plan:
- **Reset/idle.** reset high 3 cycles → o_ready=0, o_res_valid=0 during reset; o_ready=1 on the first cycle after reset deasserts.
- **Streaming read.**
  - Stimulus: preload word[k]=k*0x11111111, LATENCY=2. Read addresses 0,4,8,12 back-to-back with i_res_ready=1.
  - Response: responses 0x0, 0x11111111, 0x22222222, 0x33333333 on consecutive cycles, the first one 2 cycles after the first accept.
- **Byte strobe (macro defined).**
  - Stimulus: word[1]=0xAABBCCDD. Write addr 4, data 0x11223344, strb 4'b0101. Then read addr 4.
  - Response: 0xAA22CC44, o_err=0. With the macro undefined, the same read returns 0x11223344.
- **Backpressure/credits.**
  - Stimulus: RESP_DEPTH=4, i_res_ready=0. Issue 6 reads with i_valid held.
  - Response: exactly 4 accepted, then o_ready=0. Raise i_res_ready: responses arrive in order and the remaining 2 are accepted; the head response holds stable while stalled.
- **Errors.** Read addr 0x2, and write addr DEPTH_WORDS*4 → both responses o_err=1, o_data=0. A subsequent read of the last word is unchanged.
- **Reset mid-flight.**
  - Stimulus: accept 3 requests, including a write of 0xDEADBEEF to addr 8. Assert reset before any response.
  - Response: no responses are delivered. After reset, a read of addr 8 returns 0xDEADBEEF.

Source files
------------

// File: rtl/pipe_memory_pkg.sv
// Shared definitions for pipe_memory: command encoding, response record layout
// and a compile-time clog2 helper.
package pipe_memory_pkg;

    localparam int MEM_CMD_WIDTH = 32'sd1;

    typedef enum logic [MEM_CMD_WIDTH-1:0] {
        MEM_CMD_READ  = 1'b0,
        MEM_CMD_WRITE = 1'b1
    } mem_cmd_e;

    // A response record is packed as {err, data}: the err flag sits directly above the data word.
    localparam int RESP_ERR_BITS = 32'sd1;

    function automatic int mem_clog2(input int value);
        int result;
        result = 32'sd0;
        for (int i = 32'sd0; i < 32'sd31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 32'sd1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/pipe_memory_resp_fifo.sv
// mem_resp_fifo: circular response buffer; the head entry is presented while out_valid
// is high and is released by pop. Simultaneous push and pop of a full buffer is legal.
module mem_resp_fifo
    import pipe_memory_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid
);

    localparam int PTR_BITS = (DEPTH > 32'sd1) ? mem_clog2(DEPTH) : 32'sd1;
    localparam int CNT_BITS = mem_clog2(DEPTH + 32'sd1);
    localparam logic [PTR_BITS-1:0] PTR_LAST = PTR_BITS'(DEPTH - 32'sd1);
    localparam logic [PTR_BITS-1:0] PTR_ONE  = PTR_BITS'(32'd1);
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(32'd1);

    logic [WIDTH-1:0]    storage_r [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr_r;
    logic [PTR_BITS-1:0] rd_ptr_r;
    logic [PTR_BITS-1:0] wr_ptr_next_s;
    logic [PTR_BITS-1:0] rd_ptr_next_s;
    logic [CNT_BITS-1:0] count_r;
    logic [CNT_BITS-1:0] count_next_s;
    logic                valid_r;
    logic                pop_s;

    function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] ptr);
        if (ptr == PTR_LAST) begin
            return '0;
        end else begin
            return ptr + PTR_ONE;
        end
    endfunction

    // Next pointer and occupancy values.
    always_comb begin
        pop_s = pop && valid_r;
        if (push) begin
            wr_ptr_next_s = ptr_inc(wr_ptr_r);
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_next_s = ptr_inc(rd_ptr_r);
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
        case ({push, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Pointer, occupancy and valid-flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            valid_r  <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_next_s;
            rd_ptr_r <= rd_ptr_next_s;
            count_r  <= count_next_s;
            valid_r  <= (count_next_s != '0);
        end
    end

    // Entry storage; contents need no reset because valid_r gates the head.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            storage_r[wr_ptr_r] <= push_data;
        end
    end

    assign out_valid = valid_r;
    assign out_data  = valid_r ? storage_r[rd_ptr_r] : '0;

endmodule

// File: rtl/pipe_memory.sv
// pipe_memory: pipelined in-order word memory with credit flow control and error responses.
// Build macro PIPE_MEM_BYTE_STROBE_EN enables byte-strobed partial writes (full-word writes otherwise).
module pipe_memory
    import pipe_memory_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH_WORDS   = 1024,
    parameter int LATENCY       = 2,
    parameter int RESP_DEPTH    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDRESS_WIDTH-1:0]  i_address,
    input  logic                      i_cmd,
    input  logic [DATA_WIDTH-1:0]     i_data,
    input  logic [DATA_WIDTH/8-1:0]   i_strb,
    input  logic                      i_valid,
    output logic                      o_ready,
    output logic [DATA_WIDTH-1:0]     o_data,
    output logic                      o_err,
    output logic                      o_res_valid,
    input  logic                      i_res_ready
);

    localparam int BYTE_BITS   = 32'sd8;
    localparam int BYTES       = DATA_WIDTH / BYTE_BITS;
    localparam int OFFSET_BITS = mem_clog2(BYTES);
    localparam int IDX_BITS    = (DEPTH_WORDS > 32'sd1) ? mem_clog2(DEPTH_WORDS) : 32'sd1;
    localparam int CNT_BITS    = mem_clog2(RESP_DEPTH + 32'sd1);
    localparam int RESP_WIDTH  = DATA_WIDTH + RESP_ERR_BITS;
    localparam logic [ADDRESS_WIDTH-1:0] OFFSET_MASK  = ADDRESS_WIDTH'(BYTES - 32'sd1);
    localparam logic [ADDRESS_WIDTH-1:0] DEPTH_LIMIT  = ADDRESS_WIDTH'(DEPTH_WORDS);
    localparam logic [CNT_BITS-1:0]      CREDIT_LIMIT = CNT_BITS'(RESP_DEPTH);
    localparam logic [CNT_BITS-1:0]      CNT_ONE      = CNT_BITS'(32'd1);

    logic [DATA_WIDTH-1:0]    mem_r [DEPTH_WORDS];
    logic [LATENCY-1:0]       stage_valid_r;
    logic [LATENCY-1:0]       stage_err_r;
    logic [DATA_WIDTH-1:0]    stage_data_r [LATENCY];
    logic [CNT_BITS-1:0]      outstanding_r;
    logic [CNT_BITS-1:0]      outstanding_next_s;
    logic                     o_ready_r;
    logic                     accept_s;
    logic                     handshake_s;
    logic                     is_write_s;
    logic                     addr_err_s;
    logic [ADDRESS_WIDTH-1:0] word_idx_s;
    logic [IDX_BITS-1:0]      mem_idx_s;
    logic [DATA_WIDTH-1:0]    read_word_s;
    logic [DATA_WIDTH-1:0]    write_word_s;
    logic [RESP_WIDTH-1:0]    fifo_out_s;
    logic                     fifo_valid_s;

    // Request decode, read sampling and credit bookkeeping.
    always_comb begin
        accept_s    = i_valid && o_ready_r;
        handshake_s = fifo_valid_s && i_res_ready;
        is_write_s  = (i_cmd == MEM_CMD_WRITE);
        word_idx_s  = i_address >> OFFSET_BITS;
        mem_idx_s   = word_idx_s[IDX_BITS-1:0];
        addr_err_s  = ((i_address & OFFSET_MASK) != '0) || (word_idx_s >= DEPTH_LIMIT);
        if (is_write_s || addr_err_s) begin
            read_word_s = '0;
        end else begin
            read_word_s = mem_r[mem_idx_s];
        end
        case ({accept_s, handshake_s})
            2'b10:   outstanding_next_s = outstanding_r + CNT_ONE;
            2'b01:   outstanding_next_s = outstanding_r - CNT_ONE;
            default: outstanding_next_s = outstanding_r;
        endcase
    end

`ifdef PIPE_MEM_BYTE_STROBE_EN
    // Merge strobed bytes of the write data into the stored word.
    always_comb begin
        write_word_s = mem_r[mem_idx_s];
        for (int b = 32'sd0; b < BYTES; b++) begin
            if (i_strb[b]) begin
                write_word_s[b*BYTE_BITS +: BYTE_BITS] = i_data[b*BYTE_BITS +: BYTE_BITS];
            end else begin
                write_word_s[b*BYTE_BITS +: BYTE_BITS] = mem_r[mem_idx_s][b*BYTE_BITS +: BYTE_BITS];
            end
        end
    end
`else
    // Strobes are kept on the port but every write replaces the full word.
    logic unused_strb_s;
    assign unused_strb_s = ^i_strb;

    // Full-word write data.
    always_comb begin
        write_word_s = i_data;
    end
`endif

    // Storage write commits in the acceptance cycle; errored writes leave memory untouched.
    always_ff @(posedge clk) begin
        if (accept_s && is_write_s && !addr_err_s && !reset) begin
            mem_r[mem_idx_s] <= write_word_s;
        end
    end

    // Latency pipeline control and credit counter; o_ready follows the next-state count.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_valid_r <= '0;
            stage_err_r   <= '0;
            outstanding_r <= '0;
            o_ready_r     <= 1'b0;
        end else begin
            stage_valid_r[0] <= accept_s;
            stage_err_r[0]   <= addr_err_s;
            for (int s = 32'sd1; s < LATENCY; s++) begin
                stage_valid_r[s] <= stage_valid_r[s-32'sd1];
                stage_err_r[s]   <= stage_err_r[s-32'sd1];
            end
            outstanding_r <= outstanding_next_s;
            o_ready_r     <= (outstanding_next_s < CREDIT_LIMIT);
        end
    end

    // Latency pipeline data path; qualified by stage_valid_r so no reset is needed.
    always_ff @(posedge clk) begin
        stage_data_r[0] <= read_word_s;
        for (int s = 32'sd1; s < LATENCY; s++) begin
            stage_data_r[s] <= stage_data_r[s-32'sd1];
        end
    end

    mem_resp_fifo #(
        .WIDTH (RESP_WIDTH),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (stage_valid_r[LATENCY-1]),
        .push_data ({stage_err_r[LATENCY-1], stage_data_r[LATENCY-1]}),
        .pop       (i_res_ready),
        .out_data  (fifo_out_s),
        .out_valid (fifo_valid_s)
    );

    assign o_ready     = o_ready_r;
    assign o_res_valid = fifo_valid_s;
    assign o_err       = fifo_out_s[DATA_WIDTH];
    assign o_data      = fifo_out_s[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_pipe_memory.sv
// Scoreboard bench for pipe_memory: a reference model predicts each response at acceptance,
// a negedge monitor checks responses in order as the DUT presents them.
module tb_pipe_memory;

    localparam int LAT   = 2;
    localparam int RDEP  = 4;
    localparam int DEPTH = 1024;
    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

    logic        clk;
    logic        reset;
    logic [31:0] i_address;
    logic        i_cmd;
    logic [31:0] i_data;
    logic [3:0]  i_strb;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] o_data;
    logic        o_err;
    logic        o_res_valid;
    logic        i_res_ready;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [int];
    int          n_tests;
    int          n_fail;
    int          n_accepts;
    int          n_resp;
    int          cyc;
    bit          rand_rdy_en;

    pipe_memory #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .DEPTH_WORDS   (DEPTH),
        .LATENCY       (LAT),
        .RESP_DEPTH    (RDEP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_address   (i_address),
        .i_cmd       (i_cmd),
        .i_data      (i_data),
        .i_strb      (i_strb),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_data      (o_data),
        .o_err       (o_err),
        .o_res_valid (o_res_valid),
        .i_res_ready (i_res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: decide the response of one accepted request from the access rules.
    function automatic exp_t model_access(input logic cmd, input logic [31:0] addr,
                                          input logic [31:0] data, input logic [3:0] strb);
        exp_t        e;
        int unsigned idx;
        logic [31:0] old;
        logic [31:0] nw;
        idx   = addr / 4;
        e.err = ((addr % 4) != 0) || (idx >= DEPTH);
        e.data = 32'h0;
        e.acc  = cyc;
        e.lat  = 1'b0;
        if (!e.err) begin
            old = model_mem.exists(int'(idx)) ? model_mem[int'(idx)] : 32'h0;
            if (cmd == CMD_WR) begin
`ifdef PIPE_MEM_BYTE_STROBE_EN
                nw = old;
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) nw[b*8 +: 8] = data[b*8 +: 8];
                end
`else
                nw = data;
`endif
                model_mem[int'(idx)] = nw;
            end else begin
                e.data = old;
            end
        end
        return e;
    endfunction

    // Present one request and hold it until accepted (bounded wait).
    task automatic issue(input logic cmd, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input bit lat);
        int   waited;
        bit   done;
        exp_t e;
        waited = 0;
        done   = 1'b0;
        i_valid = 1'b1; i_cmd = cmd; i_address = addr; i_data = data; i_strb = strb;
        while (!done) begin
            @(negedge clk);
            if (o_ready === 1'b1) begin
                @(posedge clk);
                #1;
                e = model_access(cmd, addr, data, strb);
                e.lat = lat;
                exp_q.push_back(e);
                n_accepts++;
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 200) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL accept_timeout: addr 0x%0h never accepted, required accept within 200 cycles", addr);
                    done = 1'b1;
                end
            end
        end
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            @(posedge clk);
            w++;
        end
        #1;
        check("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: compare the presented response with the scoreboard head.
    always @(negedge clk) begin
        if (reset === 1'b0 && o_res_valid === 1'b1) begin
            if (i_res_ready) n_resp++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_resp: got data 0x%0h err %0b, required no response", o_data, o_err);
            end else begin
                check("resp_data", 64'(o_data), 64'(exp_q[0].data));
                check("resp_err", 64'(o_err), 64'(exp_q[0].err));
                if (exp_q[0].lat) check("resp_latency", 64'(cyc - exp_q[0].acc), 64'(LAT));
                if (i_res_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int base;
        int r;
        logic [31:0] addr;
        n_tests = 0; n_fail = 0; n_accepts = 0; n_resp = 0; cyc = 0;
        rand_rdy_en = 1'b0;
        reset = 1'b1; i_valid = 1'b0; i_cmd = CMD_RD; i_address = 32'h0;
        i_data = 32'h0; i_strb = 4'h0; i_res_ready = 1'b1;

        // Reset / idle
        repeat (3) begin
            @(negedge clk);
            check("reset_ready", 64'(o_ready), 64'd0);
            check("reset_res_valid", 64'(o_res_valid), 64'd0);
            check("reset_data_err", 64'({o_err, o_data}), 64'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_reset", 64'(o_ready), 64'd1);
        @(posedge clk); #1;

        // Preload words 0..15 and the last word
        for (int k = 0; k < 16; k++) issue(CMD_WR, 32'(k * 4), 32'(k) * 32'h11111111, 4'hF, 1'b0);
        issue(CMD_WR, 32'((DEPTH - 1) * 4), 32'h0BADF00D, 4'hF, 1'b0);
        drain();

        // Streaming reads with latency check
        for (int k = 0; k < 4; k++) issue(CMD_RD, 32'(k * 4), 32'h0, 4'h0, 1'b1);
        drain();

        // Byte strobe (full word when strobes are disabled)
        issue(CMD_WR, 32'h4, 32'hAABBCCDD, 4'hF, 1'b0);
        issue(CMD_WR, 32'h4, 32'h11223344, 4'b0101, 1'b0);
        issue(CMD_RD, 32'h4, 32'h0, 4'h0, 1'b1);
        drain();

        // Backpressure / credits
        i_res_ready = 1'b0;
        base = n_accepts;
        fork
            begin
                for (int k = 0; k < 6; k++) issue(CMD_RD, 32'(k * 4), 32'h0, 4'h0, 1'b0);
            end
            begin
                repeat (8) @(posedge clk);
                @(negedge clk);
                check("credit_accepts", 64'(n_accepts - base), 64'(RDEP));
                check("credit_ready_low", 64'(o_ready), 64'd0);
                i_res_ready = 1'b1;
            end
        join
        drain();
        check("credit_total", 64'(n_accepts - base), 64'd6);

        // Error responses and unchanged last word
        issue(CMD_RD, 32'h2, 32'h0, 4'h0, 1'b0);
        issue(CMD_WR, 32'(DEPTH * 4), 32'hFFFFFFFF, 4'hF, 1'b0);
        issue(CMD_RD, 32'((DEPTH - 1) * 4), 32'h0, 4'h0, 1'b0);
        issue(CMD_RD, 32'h0, 32'h0, 4'h0, 1'b0);
        drain();

        // Randomized traffic with random backpressure
        rand_rdy_en = 1'b1;
        fork
            begin
                while (rand_rdy_en) begin
                    @(posedge clk); #1;
                    i_res_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 19));
            if (r == 0) addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            else if (r == 1) addr = 32'((DEPTH + $urandom_range(0, 1000)) * 4);
            else if (r == 2) addr = 32'((DEPTH - 1) * 4);
            else addr = 32'($urandom_range(0, 15) * 4);
            issue(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)), 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        rand_rdy_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        i_res_ready = 1'b1;
        drain();

        // Reset mid-flight: in-flight requests vanish, the accepted write stays
        i_res_ready = 1'b0;
        issue(CMD_WR, 32'h8, 32'hDEADBEEF, 4'hF, 1'b0);
        issue(CMD_RD, 32'h0, 32'h0, 4'h0, 1'b0);
        issue(CMD_RD, 32'hC, 32'h0, 4'h0, 1'b0);
        reset = 1'b1;
        exp_q.delete();
        base = n_resp;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        i_res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_midreset", 64'(o_ready), 64'd1);
        repeat (8) @(posedge clk);
        #1;
        check("flush_no_resp", 64'(n_resp - base), 64'd0);
        issue(CMD_RD, 32'h8, 32'h0, 4'h0, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
